// File: rtl/fifo_pkg.sv
// Shared FIFO types: the registered status bundle and a width helper.
// Reused by the FIFO variants of the datapath.
package fifo_pkg;

  typedef struct packed {
    logic empty;
    logic almostEmpty;
    logic full;
    logic almostFull;
    logic valid;
    logic wrap;
  } fifo_status_t;

  // Bits needed to index 'value' distinct codes (matches $clog2).
  function automatic int fifo_clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/fifo_mod_counter.sv
// Modulo-DEPTH pointer: optional load, then optional increment, wrapping DEPTH-1 -> 0.
// Exposes the next value so the owner can look ahead one edge.
module fifo_mod_counter #(
  parameter int DEPTH   = 24,
  parameter int PTRBITS = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               load,
  input  logic [PTRBITS-1:0] loadValue,
  output logic [PTRBITS-1:0] value,
  output logic [PTRBITS-1:0] value_next
);

  logic [PTRBITS-1:0] value_q, value_d, base;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    base    = load ? loadValue : value_q;
    value_d = base;
    if (inc) value_d = (base == PTRBITS'(DEPTH - 1)) ? '0 : base + PTRBITS'(1);
  end

  // NOTE: state updates use non-blocking assignments so all flops sample the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value      = value_q;
  assign value_next = value_d;

endmodule

// File: rtl/fifo_replay.sv
// Show-ahead FIFO of arbitrary depth with sticky error flags and a replay mode.
// Replay logic is built only when FIFO_REPLAY_EN is defined.
module fifo_replay
  import fifo_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 24,
  parameter int ALMOST_FULL  = 1,
  parameter int ALMOST_EMPTY = 1,
  localparam int FILLBITS    = fifo_clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                replay,
  input  logic [WIDTH-1:0]    datain,
  input  logic                write,
  input  logic                read,
  output logic [WIDTH-1:0]    dataout,
  output logic                valid,
  output logic                empty,
  output logic                almostEmpty,
  output logic                full,
  output logic                almostFull,
  output logic [FILLBITS-1:0] fillLevel,
  output logic                wrap,
  output logic                overflow,
  output logic                underflow
);

  localparam int PTRBITS = fifo_clog2(DEPTH);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTRBITS-1:0]  wr_q, rd_q, rd_d, rd_idx, wr_next_unused;
  logic [FILLBITS-1:0] fill_q, fill_d;
  logic [WIDTH-1:0]    dataout_q, dataout_d;
  fifo_status_t        status_q, status_d;
  logic                overflow_q, overflow_d, underflow_q, underflow_d;
  logic                replay_mode, rd_acc, wr_acc, pop, wrap_evt;

  assign rd_acc = read && status_q.valid && !flush;
  assign wr_acc = write && !flush && ((fill_q < FILLBITS'(DEPTH)) || (rd_acc && !replay_mode));
  assign pop    = rd_acc && !replay_mode;

  fifo_mod_counter #(.DEPTH(DEPTH), .PTRBITS(PTRBITS)) u_wr_ptr (
    .clk(clk), .rst_n(reset_n), .inc(wr_acc), .load(flush), .loadValue('0),
    .value(wr_q), .value_next(wr_next_unused)
  );

  fifo_mod_counter #(.DEPTH(DEPTH), .PTRBITS(PTRBITS)) u_rd_ptr (
    .clk(clk), .rst_n(reset_n), .inc(pop), .load(flush), .loadValue('0),
    .value(rd_q), .value_next(rd_d)
  );

`ifdef FIFO_REPLAY_EN
  logic               replay_q, replay_rise, rp_load, rp_inc;
  logic [PTRBITS-1:0] rp_q, rp_d, rp_cur, rp_load_value, newest;

  assign replay_mode = replay;
  assign replay_rise = replay && !replay_q;

  // A read on the rising cycle acts on the freshly loaded pointer (load, then inc).
  always_comb begin
    rp_cur        = replay_rise ? rd_q : rp_q;
    newest        = (wr_q == '0) ? PTRBITS'(DEPTH - 1) : wr_q - PTRBITS'(1);
    wrap_evt      = replay && rd_acc && (rp_cur == newest);
    rp_load       = flush || replay_rise || wrap_evt;
    rp_load_value = flush ? '0 : rd_q;
    rp_inc        = replay && rd_acc && !wrap_evt;
  end

  fifo_mod_counter #(.DEPTH(DEPTH), .PTRBITS(PTRBITS)) u_rp_ptr (
    .clk(clk), .rst_n(reset_n), .inc(rp_inc), .load(rp_load), .loadValue(rp_load_value),
    .value(rp_q), .value_next(rp_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) replay_q <= 1'b0;
    else          replay_q <= replay;
  end

  assign rd_idx = replay ? rp_d : rd_d;
`else
  logic replay_unused;
  assign replay_unused = replay;
  assign replay_mode   = 1'b0;
  assign wrap_evt      = 1'b0;
  assign rd_idx        = rd_d;
`endif

  always_comb begin
    fill_d = fill_q;
    if (flush)                fill_d = '0;
    else if (wr_acc && !pop)  fill_d = fill_q + FILLBITS'(1);
    else if (pop && !wr_acc)  fill_d = fill_q - FILLBITS'(1);

    overflow_d  = !flush && (overflow_q  || (write && !wr_acc));
    underflow_d = !flush && (underflow_q || (read && !status_q.valid));

    status_d.valid       = (fill_d != '0);
    status_d.empty       = (fill_d == '0);
    status_d.almostEmpty = (fill_d <= FILLBITS'(ALMOST_EMPTY));
    status_d.full        = (fill_d == FILLBITS'(DEPTH));
    status_d.almostFull  = ((FILLBITS'(DEPTH) - fill_d) <= FILLBITS'(ALMOST_FULL));
    status_d.wrap        = wrap_evt;

    // The word being written this edge is not in mem yet, so forward it.
    dataout_d = '0;
    if (status_d.valid) dataout_d = (wr_acc && (rd_idx == wr_q)) ? datain : mem[rd_idx];
  end

  // NOTE: the storage array has no reset; only pointers and fill decide what is readable.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_q] <= datain;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_q      <= '0;
      dataout_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      status_q    <= '{empty: 1'b1, almostEmpty: 1'b1, full: 1'b0,
                       almostFull: 1'b0, valid: 1'b0, wrap: 1'b0};
    end else begin
      fill_q      <= fill_d;
      dataout_q   <= dataout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      status_q    <= status_d;
    end
  end

  assign dataout     = dataout_q;
  assign valid       = status_q.valid;
  assign empty       = status_q.empty;
  assign almostEmpty = status_q.almostEmpty;
  assign full        = status_q.full;
  assign almostFull  = status_q.almostFull;
  assign wrap        = status_q.wrap;
  assign fillLevel   = fill_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_fifo_replay.sv
// Self-checking bench for fifo_replay: directed vector table, corner-case sequences,
// and a randomized run against a queue-based reference model.
module tb_fifo_replay;

  localparam int DEPTH = 24;
`ifdef FIFO_REPLAY_EN
  localparam bit REPLAY_BUILT = 1'b1;
`else
  localparam bit REPLAY_BUILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, flush, replay, write, read;
  logic [31:0] datain, dataout;
  logic        valid, empty, almostEmpty, full, almostFull, wrap, overflow, underflow;
  logic [4:0]  fillLevel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_replay #(.WIDTH(32), .DEPTH(DEPTH), .ALMOST_FULL(1), .ALMOST_EMPTY(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .replay(replay), .datain(datain),
    .write(write), .read(read), .dataout(dataout), .valid(valid), .empty(empty),
    .almostEmpty(almostEmpty), .full(full), .almostFull(almostFull),
    .fillLevel(fillLevel), .wrap(wrap), .overflow(overflow), .underflow(underflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] flag_vec();
    return {valid, empty, almostEmpty, full, almostFull, wrap, overflow, underflow};
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_dataout"}, dataout, 0);
    check({tag, "_flags"}, flag_vec(), 8'b0110_0000);
    check({tag, "_fill"}, fillLevel, 0);
  endtask

  // Reference model: stored words as a queue, replay position as an offset from the head.
  logic [31:0] mq[$];
  logic        m_valid, m_ovf, m_unf, m_wrap, m_replay_prev;
  logic [31:0] m_dout;
  int          m_rp;

  task automatic model_step(input logic fl, input logic wr, input logic rd,
                            input logic rp, input logic [31:0] d);
    logic mode, rd_ok, wr_ok;
    int   cur;
    mode = REPLAY_BUILT && rp;
    if (fl) begin
      mq.delete();
      m_ovf = 0; m_unf = 0; m_wrap = 0; m_valid = 0; m_rp = 0;
    end else begin
      rd_ok = rd && m_valid;
      if (rd && !m_valid) m_unf = 1;
      wr_ok = wr && ((mq.size() < DEPTH) || (rd_ok && !mode));
      if (wr && !wr_ok) m_ovf = 1;
      m_wrap = 0;
      if (mode) begin
        cur = m_replay_prev ? m_rp : 0;
        if (rd_ok) begin
          if (cur == mq.size() - 1) begin
            cur    = 0;
            m_wrap = 1;
          end else begin
            cur++;
          end
        end
        m_rp = cur;
      end else if (rd_ok) begin
        void'(mq.pop_front());
      end
      if (wr_ok) mq.push_back(d);
      m_valid = (mq.size() > 0);
    end
    m_dout        = m_valid ? (mode ? mq[m_rp] : mq[0]) : 32'h0;
    m_replay_prev = rp;
  endtask

  typedef struct {
    logic        fl, wr, rd;
    logic [31:0] din;
    logic        e_valid;
    logic [31:0] e_dout;
    int          e_fill;
    logic        e_unf;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b0, 32'hA, 1'b1, 32'hA, 1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'hB, 1'b1, 32'hA, 2, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b1, 32'hB, 1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 32'hC, 1'b1, 32'hC, 1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 32'hD, 1'b1, 32'hD, 1, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 32'hE, 1'b0, 32'h0, 0, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 32'hE, 1'b1, 32'hE, 1, 1'b0};

    reset_n = 1'b0; flush = 1'b0; replay = 1'b0; write = 1'b0; read = 1'b0; datain = '0;
    #12;
    check_reset_values("reset");
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      flush = vecs[i].fl; write = vecs[i].wr; read = vecs[i].rd; datain = vecs[i].din;
      tick();
      check($sformatf("vec%0d_valid", i), valid, vecs[i].e_valid);
      check($sformatf("vec%0d_fill", i), fillLevel, vecs[i].e_fill);
      check($sformatf("vec%0d_empty", i), empty, vecs[i].e_fill == 0);
      check($sformatf("vec%0d_underflow", i), underflow, vecs[i].e_unf);
      if (vecs[i].e_valid) check($sformatf("vec%0d_dataout", i), dataout, vecs[i].e_dout);
    end
    flush = 1'b1; write = 1'b0; read = 1'b0;
    tick();
    flush = 1'b0;

    // Fill to DEPTH, watching the almost-full and full boundaries
    for (int i = 0; i < DEPTH; i++) begin
      write = 1'b1; datain = i;
      tick();
      if (i == DEPTH - 3) check("fill_af_low", almostFull, 1'b0);
      if (i == DEPTH - 2) check("fill_af_edge", {almostFull, full}, 2'b10);
    end
    write = 1'b0;
    check("fill_full", {full, almostFull, empty}, 3'b110);
    check("fill_level", fillLevel, DEPTH);

    // Pass-through at full: reads drain 0..23 then the 99s, fill holds
    for (int i = 0; i < 30; i++) begin
      check($sformatf("pt_data%0d", i), dataout, (i < DEPTH) ? i : 99);
      read = 1'b1; write = 1'b1; datain = 99;
      tick();
      check($sformatf("pt_fill%0d", i), fillLevel, DEPTH);
      check($sformatf("pt_ovf%0d", i), overflow, 1'b0);
    end
    read = 1'b0;

    // Write to full without read: rejected
    datain = 1234;
    tick();
    write = 1'b0;
    check("ovf_set", overflow, 1'b1);
    check("ovf_fill", fillLevel, DEPTH);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_state", {fillLevel, overflow, empty, valid}, {5'd0, 1'b0, 1'b1, 1'b0});

    // Empty read
    read = 1'b1;
    tick();
    read = 1'b0;
    check("unf_set", underflow, 1'b1);
    check("unf_fill", fillLevel, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("unf_clear", underflow, 1'b0);

`ifdef FIFO_REPLAY_EN
    begin
      logic [31:0] seq [7];
      seq = '{5, 6, 7, 5, 6, 7, 5};
      for (int i = 5; i <= 7; i++) begin
        write = 1'b1; datain = i;
        tick();
      end
      write = 1'b0; replay = 1'b1;
      tick();
      check("rp_start", {dataout, fillLevel, wrap}, {32'd5, 5'd3, 1'b0});
      for (int k = 1; k <= 7; k++) begin
        check($sformatf("rp_data%0d", k), dataout, seq[k-1]);
        read = 1'b1;
        tick();
        check($sformatf("rp_wrap%0d", k), wrap, (k == 3) || (k == 6));
        check($sformatf("rp_fill%0d", k), fillLevel, 3);
      end
      read = 1'b0; replay = 1'b0;
      tick();
      check("rp_exit", {valid, dataout}, {1'b1, 32'd5});
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end
`endif

    // Randomized run against the reference model
    mq.delete();
    m_valid = 0; m_ovf = 0; m_unf = 0; m_wrap = 0; m_rp = 0; m_replay_prev = 0;
    replay = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      int fill_e;
      flush  = ($urandom_range(0, 99) == 0);
      write  = $urandom_range(0, 1);
      read   = $urandom_range(0, 1);
      datain = $urandom;
      if ($urandom_range(0, 39) == 0) replay = ~replay;
      model_step(flush, write, read, replay, datain);
      tick();
      fill_e = mq.size();
      check("rand_flags", flag_vec(),
            {m_valid, fill_e == 0, fill_e <= 1, fill_e == DEPTH, (DEPTH - fill_e) <= 1,
             m_wrap, m_ovf, m_unf});
      check("rand_fill", fillLevel, fill_e);
      if (m_valid) check("rand_dataout", dataout, m_dout);
      check("ptr_range", (u_dut.u_wr_ptr.value < DEPTH) && (u_dut.u_rd_ptr.value < DEPTH), 1'b1);
    end

    // Asynchronous reset between edges during a write burst
    flush = 1'b0; read = 1'b0; replay = 1'b0;
    for (int i = 0; i < 4; i++) begin
      write = 1'b1; datain = $urandom;
      tick();
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    write = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
